// File: rtl/sync_fifo_pkg.sv
// Shared project constants for the synchronous FIFO: default word and address widths.
package sync_fifo_pkg;

  localparam int DEF_B = 8;
  localparam int DEF_W = 2;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a FIFO producer/consumer (master) and the FIFO (slave).
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int W = DEF_W
);

  logic         wr;
  logic         rd;
  logic [B-1:0] w_data;
  logic [B-1:0] r_data;
  logic         empty;
  logic         full;
  logic         almost_full;
  logic [W:0]   count;
  logic         ovf;
  logic         unf;

  modport master (
    output wr, rd, w_data,
    input  r_data, empty, full, almost_full, count, ovf, unf
  );

  modport slave (
    input  wr, rd, w_data,
    output r_data, empty, full, almost_full, count, ovf, unf
  );

endinterface : sync_fifo_if

// File: rtl/sync_fifo_regfile.sv
// Team register file: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_regfile
  import sync_fifo_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [W-1:0] waddr_i,
  input  logic [B-1:0] wdata_i,
  input  logic [W-1:0] raddr_i,
  output logic [B-1:0] rdata_o
);

  logic [B-1:0] mem_q [2**W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : sync_fifo_regfile

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered occupancy flags and sticky
// overflow/underflow indicators.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int B        = DEF_B,
  parameter int W        = DEF_W,
  parameter int AF_LEVEL = 2**W - 1
) (
  input  logic         clk,
  input  logic         reset,
  sync_fifo_if.slave   bus
);

  localparam logic [W:0] DEPTH_C  = (W+1)'(2**W);
  localparam logic [W:0] CNT_ONE  = (W+1)'(1);
  localparam logic [W-1:0] PTR_ONE = W'(1);
  localparam logic       AF_RST   = (AF_LEVEL == 0);

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         af_q, af_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         wr_acc;
  logic         rd_acc;
  logic [B-1:0] rdata;

  // A write into a full FIFO is still accepted when a read frees the head slot that edge.
  always_comb begin
    wr_acc  = bus.wr && (!full_q || bus.rd);
    rd_acc  = bus.rd && !empty_q;

    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    if (wr_acc) begin
      w_ptr_d = w_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      r_ptr_d = r_ptr_q + PTR_ONE;
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_ONE;
    end

    if (bus.wr && !wr_acc) begin
      ovf_d = 1'b1;
    end
    if (bus.rd && empty_q) begin
      unf_d = 1'b1;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    af_d    = (int'(count_d) >= AF_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= AF_RST;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never cleared; reset only rewinds the pointers so stale words become unreachable.
  sync_fifo_regfile #(
    .B (B),
    .W (W)
  ) u_regfile (
    .clk     (clk),
    .we_i    (wr_acc && !reset),
    .waddr_i (w_ptr_q),
    .wdata_i (bus.w_data),
    .raddr_i (r_ptr_q),
    .rdata_o (rdata)
  );

  assign bus.r_data      = rdata;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.count       = count_q;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;

endmodule : sync_fifo
